// File: rtl/mux_1_to_8_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : mux_1_to_8_dispatch
// Purpose  : Write-side 1-to-8 dispatcher. Accepts one N_BITS request tagged
//            with a 3-bit lane selector and delivers it to exactly one of 8
//            destination lanes over a valid/ready handshake. Registered
//            output stage. Requests to lanes disabled in LANE_MASK are
//            accepted and discarded, and a one-cycle Drop_Pulse flags them.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-low reset
//            In_Valid   - request present
//            In_Ready   - request accepted this cycle when In_Valid is high
//            Selector   - destination lane of the request
//            Data_In    - request data
//            Out_Valid  - one-hot lane valid (zero when idle)
//            Out_Ready  - per-lane ready; only the held lane's bit matters
//            Data_Out   - data bus shared by all lanes
//            Drop_Pulse - one-cycle pulse for a discarded request
//            Xfer_Count - completed lane transfers, wraps silently
// Options  : MUX_1_TO_8_SKID_EN - adds a skid entry; In_Ready becomes a
//            registered signal with no combinational path from Out_Ready.
// Revision : 1.0 - initial release
// ============================================================================
module mux_1_to_8_dispatch #(
  parameter int          N_BITS     = 32,
  parameter logic [7:0]  LANE_MASK  = 8'hFF,
  parameter int          COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [2:0]            Selector,
  input  logic [N_BITS-1:0]     Data_In,
  output logic [7:0]            Out_Valid,
  input  logic [7:0]            Out_Ready,
  output logic [N_BITS-1:0]     Data_Out,
  output logic                  Drop_Pulse,
  output logic [COUNT_BITS-1:0] Xfer_Count
);

  localparam logic [1:0] c_ST_EMPTY = 2'd0;
  localparam logic [1:0] c_ST_FULL  = 2'd1;
`ifdef MUX_1_TO_8_SKID_EN
  localparam logic [1:0] c_ST_SKID  = 2'd2;
`endif

  logic [1:0]            r_state;
  logic [2:0]            r_lane;
  logic [N_BITS-1:0]     r_data;
  logic                  r_drop;
  logic [COUNT_BITS-1:0] r_count;

  logic [1:0]            w_state_nxt;
  logic                  w_sel_rdy;
  logic                  w_lane_en;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_count_inc;
  logic [7:0]            w_onehot;

`ifdef MUX_1_TO_8_SKID_EN
  logic [2:0]            r_skid_lane;
  logic [N_BITS-1:0]     r_skid_data;
  logic                  r_in_ready;
  logic                  w_skid_load;
  logic                  w_skid_move;
`endif

  // Only the held lane's ready is observed; other lanes' ready bits are ignored.
  assign w_sel_rdy = Out_Ready[r_lane];
  assign w_lane_en = LANE_MASK[Selector];
  assign w_accept  = In_Valid & In_Ready;

`ifdef MUX_1_TO_8_SKID_EN
  // Registered ready: low exactly while the skid entry is occupied.
  assign In_Ready = r_in_ready;
`else
  // When FULL, a new request can only enter on the edge the held one leaves.
  assign In_Ready = (r_state == c_ST_EMPTY) | w_sel_rdy;
`endif

  always_comb begin
    w_onehot = 8'h00;
    if (r_state != c_ST_EMPTY) begin
      w_onehot[r_lane] = 1'b1;
    end
  end

  assign Out_Valid  = w_onehot;
  assign Data_Out   = r_data;
  assign Drop_Pulse = r_drop;
  assign Xfer_Count = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_count_inc = 1'b0;
`ifdef MUX_1_TO_8_SKID_EN
    w_skid_load = 1'b0;
    w_skid_move = 1'b0;
`endif
    case (r_state)
      c_ST_EMPTY: begin
        if (w_accept && w_lane_en) begin
          w_load      = 1'b1;
          w_state_nxt = c_ST_FULL;
        end
      end
      c_ST_FULL: begin
        if (w_sel_rdy) begin
          w_count_inc = 1'b1;
          if (w_accept && w_lane_en) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = c_ST_EMPTY;
          end
        end
`ifdef MUX_1_TO_8_SKID_EN
        else if (w_accept && w_lane_en) begin
          w_skid_load = 1'b1;
          w_state_nxt = c_ST_SKID;
        end
`endif
      end
`ifdef MUX_1_TO_8_SKID_EN
      c_ST_SKID: begin
        if (w_sel_rdy) begin
          w_count_inc = 1'b1;
          w_skid_move = 1'b1;
          w_state_nxt = c_ST_FULL;
        end
      end
`endif
      default: w_state_nxt = c_ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_EMPTY;
      r_lane  <= 3'd0;
      r_data  <= '0;
      r_drop  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Drops are decided at accept time from the mask alone.
      r_drop  <= w_accept & ~w_lane_en;
      if (w_count_inc) begin
        r_count <= r_count + COUNT_BITS'(1);
      end
      if (w_load) begin
        r_lane <= Selector;
        r_data <= Data_In;
      end
`ifdef MUX_1_TO_8_SKID_EN
      else if (w_skid_move) begin
        r_lane <= r_skid_lane;
        r_data <= r_skid_data;
      end
`endif
    end
  end

`ifdef MUX_1_TO_8_SKID_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skid_lane <= 3'd0;
      r_skid_data <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != c_ST_SKID);
      if (w_skid_load) begin
        r_skid_lane <= Selector;
        r_skid_data <= Data_In;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_1_to_8_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_1_to_8_dispatch
// Purpose  : Self-checking bench for mux_1_to_8_dispatch. The reference model
//            is a FIFO of accepted (lane, data) requests with capacity 1
//            (2 with MUX_1_TO_8_SKID_EN); the front entry must be presented
//            on the output, it leaves when its lane is ready, and requests
//            to masked lanes become an expected drop pulse instead.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_1_to_8_dispatch;

  localparam int         NB   = 32;
  localparam logic [7:0] MASK = 8'hEF;
  localparam int         CB   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [2:0]    Selector = 3'd0;
  logic [NB-1:0] Data_In = '0;
  logic [7:0]    Out_Valid;
  logic [7:0]    Out_Ready = 8'hFF;
  logic [NB-1:0] Data_Out;
  logic          Drop_Pulse;
  logic [CB-1:0] Xfer_Count;

  mux_1_to_8_dispatch #(
    .N_BITS    (NB),
    .LANE_MASK (MASK),
    .COUNT_BITS(CB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Selector  (Selector),
    .Data_In   (Data_In),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Data_Out  (Data_Out),
    .Drop_Pulse(Drop_Pulse),
    .Xfer_Count(Xfer_Count)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_fail = 0;
  bit            timeout_err = 1'b0;

  // Scoreboard state: {lane, data} of accepted, not yet delivered requests.
  logic [34:0]   q[$];
  logic [CB-1:0] m_cnt = '0;
  logic [NB-1:0] last_data = '0;
  bit            exp_drop = 1'b0;
  bit            exp_rdy;
  bit            acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, compares against the model, then
  // advances the model by the handshakes that the next rising edge will take.
  initial begin
    forever begin
      @(negedge clk or negedge reset);
      if (!reset) begin
        #1;
        chk("rst_out_valid", 64'(Out_Valid), 64'h0);
        chk("rst_count", 64'(Xfer_Count), 64'h0);
        chk("rst_drop", 64'(Drop_Pulse), 64'h0);
        q.delete();
        m_cnt     = '0;
        last_data = '0;
        exp_drop  = 1'b0;
      end else begin
`ifdef MUX_1_TO_8_SKID_EN
        exp_rdy = (q.size() < 2);
`else
        exp_rdy = (q.size() == 0) || Out_Ready[q[0][34:32]];
`endif
        chk("count", 64'(Xfer_Count), 64'(m_cnt));
        chk("drop", 64'(Drop_Pulse), 64'(exp_drop));
        chk("in_ready", 64'(In_Ready), 64'(exp_rdy));
        chk("timeout", 64'(timeout_err), 64'h0);
        if (q.size() == 0) begin
          chk("out_valid_idle", 64'(Out_Valid), 64'h0);
          chk("data_hold", 64'(Data_Out), 64'(last_data));
        end else begin
          chk("out_valid", 64'(Out_Valid), 64'(8'h01 << q[0][34:32]));
          chk("data_out", 64'(Data_Out), 64'(q[0][31:0]));
        end
        exp_drop = 1'b0;
        acc = In_Valid && exp_rdy;
        if (q.size() != 0 && Out_Ready[q[0][34:32]]) begin
          last_data = q[0][31:0];
          void'(q.pop_front());
          m_cnt++;
        end
        if (acc) begin
          if (MASK[Selector]) q.push_back({Selector, Data_In});
          else                exp_drop = 1'b1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds a request until accepted, bounded to 50 cycles.
  task automatic send(input logic [2:0] s, input logic [31:0] d);
    bit done = 1'b0;
    In_Valid = 1'b1;
    Selector = s;
    Data_In  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (In_Ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    In_Valid = 1'b0;
    if (!done) begin
      $display("FAIL send_timeout: lane %0d never accepted", s);
      timeout_err = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Single transfer to lane 5.
    send(3'd5, 32'hDEADBEEF);
    idle(3);

    // Lane 2 blocked while an unrelated lane is ready.
    Out_Ready = 8'h80;
    send(3'd2, 32'h0000_2222);
    idle(5);
    Out_Ready = 8'hFF;
    idle(2);

    // Back-to-back stream over all lanes (lane 4 is masked).
    for (int k = 0; k < 8; k++) begin
      In_Valid = 1'b1;
      Selector = 3'(k);
      Data_In  = 32'(k);
      @(posedge clk);
      #1;
    end
    In_Valid = 1'b0;
    idle(3);

    // Masked lane from idle.
    send(3'd4, 32'h0000_4444);
    idle(3);

    // Second request while the first is blocked.
    Out_Ready = 8'hFD;
    send(3'd1, 32'hAAAA_0001);
    In_Valid = 1'b1;
    Selector = 3'd6;
    Data_In  = 32'hBBBB_0006;
    idle(3);
    Out_Ready = 8'hFF;
    idle(1);
    In_Valid = 1'b0;
    idle(4);

    // Randomized traffic.
    repeat (400) begin
      In_Valid  = 1'($urandom_range(0, 1));
      Selector  = 3'($urandom_range(0, 7));
      Data_In   = $urandom;
      Out_Ready = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      @(posedge clk);
      #1;
    end
    In_Valid  = 1'b0;
    Out_Ready = 8'hFF;
    idle(4);

    // Reset while holding lane 3.
    Out_Ready = 8'h00;
    send(3'd3, 32'h3333_3333);
    idle(2);
    #3 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    Out_Ready = 8'hFF;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_1_to_8_dispatch.md
Name: mux_1_to_8_dispatch

Overview:
- Write-side counterpart of the MEM-stage 8-to-1 read multiplexer.
- Takes one N_BITS write request tagged with a 3-bit Selector and delivers it to exactly one of 8 destination lanes over a valid/ready handshake.
- Registered output stage: one request in flight. Requests to masked lanes are dropped, and dropped requests are flagged.
- Sits between the MEM-stage store path and up to 8 memory-mapped write targets.

Parameters:
- N_BITS, 32, data width.
- LANE_MASK, 8'hFF, bit k=1 enables lane k; requests to disabled lanes are dropped.
- COUNT_BITS, 16, width of the delivered-transfer counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- In_Valid  input  1  request present.
- In_Ready  output  1  block accepts request this cycle.
- Selector  input  3  destination lane of request.
- Data_In  input  N_BITS  request data.
- Out_Valid  output  8  one-hot valid, bit k = lane k holds data.
- Out_Ready  input  8  per-lane ready from destinations.
- Data_Out  output  N_BITS  data bus shared by all lanes.
- Drop_Pulse  output  1  one-cycle pulse: request to disabled lane accepted and discarded.
- Xfer_Count  output  COUNT_BITS  number of completed lane transfers, wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - Out_Valid=8'h00, Data_Out=0, Drop_Pulse=0, Xfer_Count=0.
  - State=EMPTY, and the state register clears immediately.
- Handshakes:
  - Accept = In_Valid & In_Ready.
  - Lane transfer = Out_Valid[k] & Out_Ready[k].
- Out_Valid is always zero or one-hot, never multi-hot.
- Selected-lane ready: sel_rdy = Out_Ready[held lane].
- State machine (base build):
  - EMPTY: In_Ready=1.
    - Accept to an enabled lane: register Data_In and the lane; go to FULL; Out_Valid[lane]=1 next cycle (latency 1).
    - Accept to a disabled lane: no state change; Drop_Pulse=1 next cycle; Data_Out unchanged.
  - FULL: In_Ready=sel_rdy (combinational pass-through).
    - sel_rdy=1 with no accept: Xfer_Count+1, Out_Valid=0, go to EMPTY.
    - sel_rdy=1 with an accept to an enabled lane: Xfer_Count+1 and new entry loaded in the same edge; stay FULL. This gives 1 transfer/cycle back-to-back.
    - sel_rdy=1 with an accept to a disabled lane: current transfer completes, go to EMPTY, Drop_Pulse=1.
    - sel_rdy=0: hold Data_Out and Out_Valid stable; In_Ready=0.
- Out_Ready on non-selected lanes is ignored.
- Data_Out and Out_Valid must not change while Out_Valid!=0 and sel_rdy=0.
- Data_Out retains its last value after the transfer; it is not cleared.
- Xfer_Count wraps from 2^COUNT_BITS-1 to 0 with no flag. Drops are not counted.
- Reset asserted mid-transfer: the entry is discarded and Out_Valid clears immediately.
- Selector/Data_In are don't-care when In_Valid=0.

Optional Feature:
- Macro: MUX_1_TO_8_SKID_EN.
- Defined:
  - Adds a second (skid) entry plus state SKID.
  - In_Ready becomes a registered signal = !skid_full, with no combinational path from Out_Ready.
  - FULL with Accept and sel_rdy=0: the new request goes to the skid entry; go to SKID.
  - SKID: In_Ready=0. On sel_rdy=1, the skid entry moves to the output register on the same edge; go to FULL.
  - Ordering is strictly FIFO. Drops are decided at accept time and never occupy the skid entry.
- Undefined: base behaviour above; In_Ready is combinational from Out_Ready.

Test Plan:
- Reset checks:
  - Release reset with In_Valid=0 -> Out_Valid=8'h00, Xfer_Count=0, In_Ready=1, Drop_Pulse=0.
  - Assert reset while FULL on lane 3 -> Out_Valid=0 immediately, Xfer_Count=0.
- Single transfer:
  - In_Valid=1, Selector=5, Data_In=32'hDEADBEEF for 1 cycle, Out_Ready=8'hFF -> next cycle Out_Valid=8'h20, Data_Out=32'hDEADBEEF.
  - Following cycle -> Out_Valid=0, Xfer_Count=1.
- Backpressure:
  - Request to lane 2 with Out_Ready[2]=0 for 4 cycles, Out_Ready[7]=1 -> Out_Valid=8'h04 and Data_Out stable for 4 cycles, In_Ready=0 (base).
  - Out_Ready[2]=1 -> transfer completes, Xfer_Count+1.
- Streaming:
  - 8 back-to-back requests Selector=0..7, data=k, all ready -> one transfer per cycle, Out_Valid walks 01,02,...,80, Xfer_Count=8.
- Lane mask:
  - LANE_MASK=8'hEF, request Selector=4 -> Drop_Pulse=1 for one cycle, Out_Valid stays 0, Xfer_Count unchanged.
- Wrap and skid:
  - COUNT_BITS=2, 5 transfers -> Xfer_Count sequence 1,2,3,0,1.
  - With MUX_1_TO_8_SKID_EN: two accepts while the lane is blocked -> In_Ready=0 after the 2nd accept, and both are delivered in order once ready.
